// File: rtl/ssp_tx_fifo_pkg.sv
// ============================================================================
// Module  : ssp_tx_fifo_pkg
// Purpose : Shared SSP definitions. Holds the data width, TX FIFO depth,
//           pointer width and the SSP_CTRL bus-select encodings used by the
//           top-level SSP. The RX FIFO block shares these definitions.
// Ports   : (package - none)
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package ssp_tx_fifo_pkg;

  localparam int SSP_WIDTH        = 8;
  localparam int SSP_TXFIFO_DEPTH = 4;
  localparam int SSP_TXFIFO_AW    = $clog2(SSP_TXFIFO_DEPTH);

  // Bus-select encodings decoded by the top-level SSP.
  typedef enum logic [1:0] {
    SSP_CTRL_NONE   = 2'b00,
    SSP_CTRL_TXFIFO = 2'b01,
    SSP_CTRL_RXFIFO = 2'b10,
    SSP_CTRL_REGS   = 2'b11
  } ssp_ctrl_e;

endpackage

`default_nettype wire

// File: rtl/ssp_tx_fifo.sv
// ============================================================================
// Module  : ssp_tx_fifo
// Purpose : Transmit-side buffer between the processor bus and the SSP serial
//           port. Bytes from bus writes are queued in order; the oldest byte
//           is presented on TXDATA and popped when the serial port takes it.
//           SSPTXINTR is raised while the FIFO is full.
// Ports   : PCLK       in   system clock, posedge
//           CLEAR_B    in   asynchronous active-low reset
//           PSEL       in   bus select for this FIFO
//           PWRITE     in   write strobe (push when PSEL & PWRITE)
//           PWDATA     in   byte to push
//           TX_TAKEN   in   1-cycle pulse: serial port latched TXDATA
//           TXDATA     out  head-of-queue byte, 0 when empty
//           TX_VALID   out  FIFO not empty
//           SSPTXINTR  out  FIFO full
//           TX_COUNT   out  entries held, 0..DEPTH
//           TX_OVERRUN out  sticky: push attempted while full
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module ssp_tx_fifo
  import ssp_tx_fifo_pkg::*;
#(
  parameter int WIDTH = SSP_WIDTH,
  parameter int DEPTH = SSP_TXFIFO_DEPTH,
  parameter int AW    = SSP_TXFIFO_AW
) (
  input  logic           PCLK,
  input  logic           CLEAR_B,
  input  logic           PSEL,
  input  logic           PWRITE,
  input  logic [WIDTH-1:0] PWDATA,
  input  logic           TX_TAKEN,
  output logic [WIDTH-1:0] TXDATA,
  output logic           TX_VALID,
  output logic           SSPTXINTR,
  output logic [AW:0]    TX_COUNT,
  output logic           TX_OVERRUN
);

  localparam logic [AW:0] C_FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_overrun;

  logic w_full;
  logic w_empty;
  logic w_write;
  logic w_push;
  logic w_pop;

  // Full/empty come from the explicit counter so that equal pointers are
  // never ambiguous.
  assign w_full  = (r_count == C_FULL_COUNT);
  assign w_empty = (r_count == '0);
  assign w_write = PSEL & PWRITE;
  // Both qualifiers use pre-edge state: a write while full is rejected even
  // if a pop frees a slot on the same edge.
  assign w_push  = w_write & ~w_full;
  assign w_pop   = TX_TAKEN & ~w_empty;

  // Storage is deliberately not reset.
  always_ff @(posedge PCLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= PWDATA;
    end
  end

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      // Pointers wrap naturally at AW bits.
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_write && w_full) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign TXDATA     = w_empty ? '0 : r_mem[r_rd_ptr];
  assign TX_VALID   = ~w_empty;
  assign SSPTXINTR  = w_full;
  assign TX_COUNT   = r_count;
  assign TX_OVERRUN = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_ssp_tx_fifo.sv
// ============================================================================
// Module  : tb_ssp_tx_fifo
// Purpose : Self-checking bench for ssp_tx_fifo. A table of single-cycle
//           vectors covers reset, single write/pop, fill/overrun/drain and
//           the simultaneous-access corner cases; a scoreboard queue covers
//           pointer wrap, push+pop with two entries and mid-cycle reset.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ssp_tx_fifo;

  logic       PCLK;
  logic       CLEAR_B;
  logic       PSEL;
  logic       PWRITE;
  logic [7:0] PWDATA;
  logic       TX_TAKEN;
  logic [7:0] TXDATA;
  logic       TX_VALID;
  logic       SSPTXINTR;
  logic [2:0] TX_COUNT;
  logic       TX_OVERRUN;

  int n_vec;
  int n_err;

  logic [7:0] r_exp_q [$];

  ssp_tx_fifo dut (
    .PCLK       (PCLK),
    .CLEAR_B    (CLEAR_B),
    .PSEL       (PSEL),
    .PWRITE     (PWRITE),
    .PWDATA     (PWDATA),
    .TX_TAKEN   (TX_TAKEN),
    .TXDATA     (TXDATA),
    .TX_VALID   (TX_VALID),
    .SSPTXINTR  (SSPTXINTR),
    .TX_COUNT   (TX_COUNT),
    .TX_OVERRUN (TX_OVERRUN)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic       psel;
    logic       pwrite;
    logic [7:0] wdata;
    logic       taken;
    logic       exp_valid;
    logic [2:0] exp_count;
    logic       exp_intr;
    logic       exp_ovr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One bus cycle: inputs set at negedge, state sampled 1ns after posedge.
  task automatic apply(input logic s, input logic w, input logic [7:0] d,
                       input logic t);
    @(negedge PCLK);
    PSEL = s; PWRITE = w; PWDATA = d; TX_TAKEN = t;
    @(posedge PCLK);
    #1;
    PSEL = 1'b0; PWRITE = 1'b0; PWDATA = 8'h00; TX_TAKEN = 1'b0;
  endtask

  // Scoreboard step: head is compared when the serial port takes it;
  // pushed bytes are queued when driven.
  task automatic sb_step(input logic push, input logic [7:0] d,
                         input logic pop);
    int n;
    n = r_exp_q.size();
    if (pop && n > 0) begin
      chk("sb_data", int'(TXDATA), int'(r_exp_q[0]));
      void'(r_exp_q.pop_front());
    end
    if (push && n < 4) r_exp_q.push_back(d);
    apply(push, push, d, pop);
    chk("sb_count", int'(TX_COUNT), r_exp_q.size());
    chk("sb_count_max", int'(TX_COUNT <= 3'd4), 1);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    CLEAR_B = 1'b0; PSEL = 1'b0; PWRITE = 1'b0; PWDATA = 8'h00; TX_TAKEN = 1'b0;

    //                psel pwr data  tk   v  cnt  i  ovr data
    tbl.push_back(vec_t'{0, 0, 8'h00, 0, 0, 3'd0, 0, 0, 8'h00}); // idle after reset
    tbl.push_back(vec_t'{1, 1, 8'hA5, 0, 1, 3'd1, 0, 0, 8'hA5}); // write A5
    tbl.push_back(vec_t'{0, 0, 8'h00, 0, 1, 3'd1, 0, 0, 8'hA5});
    tbl.push_back(vec_t'{0, 0, 8'h00, 1, 0, 3'd0, 0, 0, 8'h00}); // taken
    tbl.push_back(vec_t'{1, 1, 8'h11, 0, 1, 3'd1, 0, 0, 8'h11});
    tbl.push_back(vec_t'{1, 1, 8'h22, 0, 1, 3'd2, 0, 0, 8'h11});
    tbl.push_back(vec_t'{1, 1, 8'h33, 0, 1, 3'd3, 0, 0, 8'h11});
    tbl.push_back(vec_t'{1, 1, 8'h44, 0, 1, 3'd4, 1, 0, 8'h11}); // full
    tbl.push_back(vec_t'{1, 1, 8'h55, 0, 1, 3'd4, 1, 1, 8'h11}); // dropped
    tbl.push_back(vec_t'{0, 0, 8'h00, 1, 1, 3'd3, 0, 1, 8'h22});
    tbl.push_back(vec_t'{0, 0, 8'h00, 1, 1, 3'd2, 0, 1, 8'h33});
    tbl.push_back(vec_t'{0, 0, 8'h00, 1, 1, 3'd1, 0, 1, 8'h44});
    tbl.push_back(vec_t'{0, 0, 8'h00, 1, 0, 3'd0, 0, 1, 8'h00});
    tbl.push_back(vec_t'{0, 0, 8'h00, 1, 0, 3'd0, 0, 1, 8'h00}); // pop empty
    tbl.push_back(vec_t'{1, 1, 8'h66, 1, 1, 3'd1, 0, 1, 8'h66}); // empty+wr+tk
    tbl.push_back(vec_t'{0, 1, 8'hFF, 0, 1, 3'd1, 0, 1, 8'h66}); // PSEL low
    tbl.push_back(vec_t'{1, 0, 8'hEE, 0, 1, 3'd1, 0, 1, 8'h66}); // PWRITE low
    tbl.push_back(vec_t'{0, 0, 8'h00, 1, 0, 3'd0, 0, 1, 8'h00});
    tbl.push_back(vec_t'{1, 1, 8'hA1, 0, 1, 3'd1, 0, 1, 8'hA1});
    tbl.push_back(vec_t'{1, 1, 8'hA2, 0, 1, 3'd2, 0, 1, 8'hA1});
    tbl.push_back(vec_t'{1, 1, 8'hA3, 0, 1, 3'd3, 0, 1, 8'hA1});
    tbl.push_back(vec_t'{1, 1, 8'hA4, 0, 1, 3'd4, 1, 1, 8'hA1});
    tbl.push_back(vec_t'{1, 1, 8'h55, 1, 1, 3'd3, 0, 1, 8'hA2}); // full+wr+tk
    tbl.push_back(vec_t'{0, 0, 8'h00, 1, 1, 3'd2, 0, 1, 8'hA3});
    tbl.push_back(vec_t'{0, 0, 8'h00, 1, 1, 3'd1, 0, 1, 8'hA4});
    tbl.push_back(vec_t'{0, 0, 8'h00, 1, 0, 3'd0, 0, 1, 8'h00});

    // Reset state while held in reset.
    #12;
    chk("rst_valid", int'(TX_VALID), 0);
    chk("rst_count", int'(TX_COUNT), 0);
    chk("rst_intr",  int'(SSPTXINTR), 0);
    chk("rst_data",  int'(TXDATA), 0);
    @(negedge PCLK);
    CLEAR_B = 1'b1;

    foreach (tbl[i]) begin
      apply(tbl[i].psel, tbl[i].pwrite, tbl[i].wdata, tbl[i].taken);
      chk($sformatf("vec%0d_valid", i), int'(TX_VALID),   int'(tbl[i].exp_valid));
      chk($sformatf("vec%0d_count", i), int'(TX_COUNT),   int'(tbl[i].exp_count));
      chk($sformatf("vec%0d_intr", i),  int'(SSPTXINTR),  int'(tbl[i].exp_intr));
      chk($sformatf("vec%0d_ovr", i),   int'(TX_OVERRUN), int'(tbl[i].exp_ovr));
      chk($sformatf("vec%0d_data", i),  int'(TXDATA),     int'(tbl[i].exp_data));
    end

    // Wrap: interleaved push/pop of 6 bytes; pointers run past DEPTH.
    begin
      logic [11:0] push_pat;
      logic [11:0] pop_pat;
      int k;
      push_pat = 12'b1101_0110_0100;
      pop_pat  = 12'b0010_1001_1011;
      k = 0;
      for (int i = 11; i >= 0; i--) begin
        sb_step(push_pat[i], 8'hC0 + 8'(k), pop_pat[i]);
        if (push_pat[i]) k++;
      end
      chk("wrap_empty", int'(TX_VALID), 0);
    end

    // Two held, write 77 with simultaneous pop.
    sb_step(1'b1, 8'hD1, 1'b0);
    sb_step(1'b1, 8'hD2, 1'b0);
    sb_step(1'b1, 8'h77, 1'b1);
    chk("pp_data", int'(TXDATA), 8'hD2);
    sb_step(1'b0, 8'h00, 1'b1);
    chk("pp_last", int'(TXDATA), 8'h77);
    sb_step(1'b0, 8'h00, 1'b1);
    chk("pp_empty", int'(TX_VALID), 0);

    // Three held, asynchronous reset mid-cycle.
    sb_step(1'b1, 8'hE1, 1'b0);
    sb_step(1'b1, 8'hE2, 1'b0);
    sb_step(1'b1, 8'hE3, 1'b0);
    chk("pre_rst_ovr", int'(TX_OVERRUN), 1);
    @(negedge PCLK);
    #2;
    CLEAR_B = 1'b0;
    #1;
    chk("arst_valid", int'(TX_VALID), 0);
    chk("arst_count", int'(TX_COUNT), 0);
    chk("arst_ovr",   int'(TX_OVERRUN), 0);
    r_exp_q.delete();
    @(negedge PCLK);
    CLEAR_B = 1'b1;
    apply(1'b1, 1'b1, 8'h5A, 1'b0);
    chk("post_rst_data",  int'(TXDATA), 8'h5A);
    chk("post_rst_valid", int'(TX_VALID), 1);
    chk("post_rst_count", int'(TX_COUNT), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
